uart_tx_cfg: RTL and testbench

- Runtime-configurable UART transmitter that succeeds the fixed 8N1 / single-baud-rate transmit path.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte with per-frame configuration: parity enable/type, 5–8 data bits, 1–2 stop bits, programmable clocks-per-bit.
- Sits between the AXI-side register/data path and the UART TX pin.

---
 rtl/uart_tx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small TX FIFO and per-frame configuration
// (data bits, parity, stop bits, clocks-per-bit) latched when each byte is popped.
module uart_tx_cfg #(
    parameter int FIFO_DEPTH    = 4,
    parameter int DIV_WIDTH     = 16,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_parity_en,
    input  logic                             cfg_parity_odd,
    input  logic [3:0]                       cfg_num_data_bits,
    input  logic [1:0]                       cfg_num_stop_bits,
    input  logic [DIV_WIDTH-1:0]             cfg_clks_per_bit,
    input  logic [MAX_DATA_BITS-1:0]         tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx,
    output logic                             busy,
    output logic                             frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, next_state;

    logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic                     push, pop;

    logic [MAX_DATA_BITS-1:0] shift_reg;
    logic [3:0]               nd_q;
    logic [1:0]               ns_q;
    logic                     pe_q, par_bit_q;
    logic [DIV_WIDTH-1:0]     cpb_q, bit_cnt;
    logic [2:0]               bit_idx;
    logic                     bit_last, data_last, stop_last;

    logic [3:0]               nd_clamp;
    logic [1:0]               ns_clamp;
    logic [DIV_WIDTH-1:0]     cpb_clamp;
    logic [MAX_DATA_BITS-1:0] data_mask, head;

    assign fifo_count = count;
    assign tx_ready   = !rst && (count < CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign busy       = (state != IDLE) || (count != '0);

    assign bit_last   = (bit_cnt == cpb_q - DIV_WIDTH'(1));
    assign data_last  = ({1'b0, bit_idx} == nd_q - 4'd1);
    assign stop_last  = (bit_idx[1:0] == ns_q - 2'd1);

    // Out-of-range configuration is clamped here so the frame engine only sees legal values
    always_comb begin
        nd_clamp = cfg_num_data_bits;
        if (cfg_num_data_bits < 4'd5)
            nd_clamp = 4'd5;
        else if (cfg_num_data_bits > 4'd8)
            nd_clamp = 4'd8;
        ns_clamp = cfg_num_stop_bits;
        if (cfg_num_stop_bits == 2'd0)
            ns_clamp = 2'd1;
        else if (cfg_num_stop_bits == 2'd3)
            ns_clamp = 2'd2;
        cpb_clamp = cfg_clks_per_bit;
        if (cfg_clks_per_bit < DIV_WIDTH'(2))
            cpb_clamp = DIV_WIDTH'(2);
        data_mask = {MAX_DATA_BITS{1'b1}} >> (4'd8 - nd_clamp);
        head      = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        tx         = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0)
                    next_state = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_last)
                    next_state = DATA;
            end
            DATA: begin
                tx = shift_reg[0];
                if (bit_last && data_last)
                    next_state = pe_q ? PARITY : STOP;
            end
            PARITY: begin
                tx = par_bit_q;
                if (bit_last)
                    next_state = STOP;
            end
            STOP: begin
                if (bit_last && stop_last) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Shadow config and parity are captured at pop so mid-frame cfg edits cannot disturb the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            nd_q      <= 4'd8;
            ns_q      <= 2'd1;
            pe_q      <= 1'b0;
            par_bit_q <= 1'b0;
            cpb_q     <= DIV_WIDTH'(2);
            bit_cnt   <= '0;
            bit_idx   <= '0;
        end else if (pop) begin
            shift_reg <= head;
            nd_q      <= nd_clamp;
            ns_q      <= ns_clamp;
            pe_q      <= cfg_parity_en;
            par_bit_q <= (^(head & data_mask)) ^ cfg_parity_odd;
            cpb_q     <= cpb_clamp;
            bit_cnt   <= '0;
            bit_idx   <= '0;
        end else if (state != IDLE) begin
            if (bit_last) begin
                bit_cnt <= '0;
                if (next_state != state)
                    bit_idx <= '0;
                else
                    bit_idx <= bit_idx + 3'd1;
                if (state == DATA)
                    shift_reg <= shift_reg >> 1;
            end else begin
                bit_cnt <= bit_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: stimulus queues hand-computed frames, a
// monitor decodes the tx line per cycle and compares against the queue.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic [3:0]  cfg_num_data_bits;
    logic [1:0]  cfg_num_stop_bits;
    logic [15:0] cfg_clks_per_bit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          cpb;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_cfg #(.FIFO_DEPTH(4), .DIV_WIDTH(16), .MAX_DATA_BITS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_parity_en     (cfg_parity_en),
        .cfg_parity_odd    (cfg_parity_odd),
        .cfg_num_data_bits (cfg_num_data_bits),
        .cfg_num_stop_bits (cfg_num_stop_bits),
        .cfg_clks_per_bit  (cfg_clks_per_bit),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx                (tx),
        .busy              (busy),
        .frame_done        (frame_done),
        .fifo_count        (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Builds the expected serial bit sequence: start, data LSB first, optional parity, stops
    function automatic exp_t make_exp(input logic [7:0] data, input int nd, input int par,
                                      input int ns, input int cpb);
        exp_t e;
        int n;
        e.bits = '0;
        n = 1;
        for (int i = 0; i < nd; i++) begin
            e.bits[n] = data[i];
            n++;
        end
        if (par >= 0) begin
            e.bits[n] = par[0];
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            e.bits[n] = 1'b1;
            n++;
        end
        e.nbits = n;
        e.cpb   = cpb;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic pe, input logic po, input logic [3:0] nd,
                           input logic [1:0] ns, input logic [15:0] cpb);
        cfg_parity_en     = pe;
        cfg_parity_odd    = po;
        cfg_num_data_bits = nd;
        cfg_num_stop_bits = ns;
        cfg_clks_per_bit  = cpb;
    endtask

    task automatic apply_stimulus(input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = tx_ready;
            tick();
        end
        tx_valid = 1'b0;
        check_output("push_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cycles && !done; n++) begin
            @(negedge clk);
            if (busy === 1'b0)
                done = 1'b1;
            tick();
        end
        check_output("wait_idle", {31'd0, done}, 32'd1);
    endtask

    // Monitor: detects each start bit, checks every cycle of the frame and its length
    initial begin : monitor
        exp_t cur;
        int   ncyc;
        int   bi;
        bit   in_frame;
        bit   wave_bad;
        int   bad_at;
        logic bad_act;
        logic bad_exp;
        logic prev_tx;
        in_frame = 1'b0;
        wave_bad = 1'b0;
        prev_tx  = 1'b1;
        ncyc     = 0;
        bad_at   = 0;
        bad_act  = 1'b0;
        bad_exp  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_frame = 1'b0;
                exp_q.delete();
                prev_tx = 1'b1;
            end else begin
                if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_frame: got start bit expected none at %0t", $time);
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        ncyc     = 0;
                        wave_bad = 1'b0;
                    end
                end
                if (in_frame) begin
                    bi = ncyc / cur.cpb;
                    if (!wave_bad && (bi >= cur.nbits || tx !== cur.bits[bi])) begin
                        wave_bad = 1'b1;
                        bad_at   = ncyc;
                        bad_act  = tx;
                        bad_exp  = (bi < cur.nbits) ? cur.bits[bi] : 1'b1;
                    end
                    ncyc++;
                    if (frame_done === 1'b1) begin
                        check_output("frame_len", ncyc, cur.nbits * cur.cpb);
                        checks++;
                        if (wave_bad) begin
                            errors++;
                            $display("[TB] FAIL frame_wave: cycle %0d got tx=%b expected %b", bad_at, bad_act, bad_exp);
                        end
                        in_frame = 1'b0;
                    end else if (ncyc > 4000) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL frame_timeout: got no frame_done expected one within 4000 cycles");
                        in_frame = 1'b0;
                    end
                end else if (frame_done === 1'b1) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stray_frame_done: got 1 expected 0 at %0t", $time);
                end
                prev_tx = tx;
            end
        end
    end

    initial begin : stimulus
        logic [7:0] bp_bytes [6];
        logic [7:0] rs_bytes [3];
        int         accept_cyc [6];
        int         idx;
        int         lows;
        bit         acc;

        bp_bytes = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hF0, 8'h5A};
        rs_bytes = '{8'h96, 8'h47, 8'hE1};
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16'd4);

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check_output("rst_tx", {31'd0, tx}, 32'd1);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_output("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        tick();

        // Baseline 8N1, cpb=4, 0xA5 pushed in cycle 0
        $display("[TB] baseline 8N1");
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back(make_exp(8'hA5, 8, -1, 1, 4));
        for (int c = 0; c <= 42; c++) begin
            @(negedge clk);
            case (c)
                1:  begin
                        check_output("b_count_c1", {29'd0, fifo_count}, 32'd1);
                        check_output("b_busy_c1", {31'd0, busy}, 32'd1);
                    end
                2:  check_output("b_start_c2", {31'd0, tx}, 32'd0);
                5:  check_output("b_start_c5", {31'd0, tx}, 32'd0);
                6:  check_output("b_d0_c6", {31'd0, tx}, 32'd1);
                10: check_output("b_d1_c10", {31'd0, tx}, 32'd0);
                38: check_output("b_stop_c38", {31'd0, tx}, 32'd1);
                40: check_output("b_fd_c40", {31'd0, frame_done}, 32'd0);
                41: check_output("b_fd_c41", {31'd0, frame_done}, 32'd1);
                42: check_output("b_busy_c42", {31'd0, busy}, 32'd0);
                default: ;
            endcase
            tick();
            if (c == 0)
                tx_valid = 1'b0;
        end

        // 7 data bits with parity, cpb=2; 0x55 has four ones in its low 7 bits
        $display("[TB] parity 7E1 / 7O1");
        set_cfg(1'b1, 1'b0, 4'd7, 2'd1, 16'd2);
        exp_q.push_back(make_exp(8'h55, 7, 0, 1, 2));
        apply_stimulus(8'h55);
        wait_idle(100);
        set_cfg(1'b1, 1'b1, 4'd7, 2'd1, 16'd2);
        exp_q.push_back(make_exp(8'h55, 7, 1, 1, 2));
        apply_stimulus(8'h55);
        wait_idle(100);
        set_cfg(1'b1, 1'b0, 4'd7, 2'd1, 16'd2);
        exp_q.push_back(make_exp(8'h55, 7, 0, 1, 2));
        apply_stimulus(8'hD5);
        wait_idle(100);

        // 5E2, cpb=3, 0xFF: five ones so even parity is 1, 27-cycle frame
        $display("[TB] 5E2 upper bits ignored");
        set_cfg(1'b1, 1'b0, 4'd5, 2'd2, 16'd3);
        exp_q.push_back(make_exp(8'h1F, 5, 1, 2, 3));
        apply_stimulus(8'hFF);
        wait_idle(100);

        // FIFO backpressure, cpb=16, valid held high across 6 bytes
        $display("[TB] fifo backpressure");
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16'd16);
        idx = 0;
        tx_data  = bp_bytes[0];
        tx_valid = 1'b1;
        for (int c = 0; c < 170; c++) begin
            @(negedge clk);
            case (c)
                4:   check_output("bp_ready_c4", {31'd0, tx_ready}, 32'd1);
                5:   begin
                         check_output("bp_ready_c5", {31'd0, tx_ready}, 32'd0);
                         check_output("bp_count_c5", {29'd0, fifo_count}, 32'd4);
                     end
                162: check_output("bp_ready_c162", {31'd0, tx_ready}, 32'd0);
                163: check_output("bp_ready_c163", {31'd0, tx_ready}, 32'd1);
                default: ;
            endcase
            acc = tx_valid && tx_ready;
            tick();
            if (acc) begin
                exp_q.push_back(make_exp(bp_bytes[idx], 8, -1, 1, 16));
                accept_cyc[idx] = c;
                idx++;
                if (idx == 6)
                    tx_valid = 1'b0;
                else
                    tx_data = bp_bytes[idx];
            end
        end
        check_output("bp_accepted", idx, 6);
        if (idx == 6)
            check_output("bp_sixth_cycle", accept_cyc[5], 163);
        wait_idle(1200);

        // Config switched mid-frame: 0x3C stays 8N1, 0x6B goes out as 7O2 (five ones, odd parity 0)
        $display("[TB] mid-frame config change");
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16'd4);
        exp_q.push_back(make_exp(8'h3C, 8, -1, 1, 4));
        apply_stimulus(8'h3C);
        exp_q.push_back(make_exp(8'h6B, 7, 0, 2, 4));
        apply_stimulus(8'h6B);
        repeat (12) tick();
        set_cfg(1'b1, 1'b1, 4'd7, 2'd2, 16'd4);
        wait_idle(200);

        // Clamping: cpb 0->2, nd 15->8, ns 0->1; then cpb 1->2, nd 2->5, ns 3->2
        $display("[TB] config clamping");
        set_cfg(1'b0, 1'b0, 4'd15, 2'd0, 16'd0);
        exp_q.push_back(make_exp(8'h81, 8, -1, 1, 2));
        apply_stimulus(8'h81);
        wait_idle(100);
        set_cfg(1'b1, 1'b0, 4'd2, 2'd3, 16'd1);
        exp_q.push_back(make_exp(8'h0E, 5, 1, 2, 2));
        apply_stimulus(8'h2E);
        wait_idle(100);
        check_output("sb_empty_pre_reset", exp_q.size(), 0);

        // Reset during DATA with two bytes still queued
        $display("[TB] reset mid-frame");
        set_cfg(1'b0, 1'b0, 4'd8, 2'd1, 16'd4);
        tx_data  = rs_bytes[0];
        tx_valid = 1'b1;
        exp_q.push_back(make_exp(rs_bytes[0], 8, -1, 1, 4));
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            case (c)
                9:  check_output("rs_count_c9", {29'd0, fifo_count}, 32'd2);
                10: check_output("rs_ready_in_rst", {31'd0, tx_ready}, 32'd0);
                11: begin
                        check_output("rs_tx_after", {31'd0, tx}, 32'd1);
                        check_output("rs_count_after", {29'd0, fifo_count}, 32'd0);
                        check_output("rs_busy_after", {31'd0, busy}, 32'd0);
                        check_output("rs_ready_after", {31'd0, tx_ready}, 32'd1);
                    end
                default: ;
            endcase
            tick();
            if (c < 2)
                tx_data = rs_bytes[c + 1];
            if (c == 2)
                tx_valid = 1'b0;
            if (c == 9)
                rst = 1'b1;
            if (c == 10)
                rst = 1'b0;
        end
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1)
                lows++;
            tick();
        end
        check_output("rs_line_quiet", lows, 0);
        check_output("sb_empty_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
